// File: rtl/immtypes_pkg.sv
// Shared decode types for the ID stage: immediate selector, opcode constants,
// ID stage state encoding and a small opcode classifier.
package immtypes_pkg;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_sel_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      VALID  = 2'd1,
      BUBBLE = 2'd2
   } id_state_e;

   typedef struct packed {
      imm_sel_e sel;
      logic     illegal;
      logic     is_load;
      logic     uses_rs1;
      logic     uses_rs2;
   } dec_t;

   // The opcode includes instr[1:0], so compressed encodings fall into default.
   function automatic dec_t decode_opcode(input logic [6:0] opc);
      dec_t d;
      d.sel      = IMM_NONE;
      d.illegal  = 1'b0;
      d.is_load  = (opc == OPC_LOAD);
      d.uses_rs1 = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
      d.uses_rs2 = (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
      case (opc)
         OPC_LOAD, OPC_OPIMM, OPC_JALR: d.sel = IMM_I;
         OPC_STORE:                     d.sel = IMM_S;
         OPC_BRANCH:                    d.sel = IMM_B;
         OPC_LUI, OPC_AUIPC:            d.sel = IMM_U;
         OPC_JAL:                       d.sel = IMM_J;
         OPC_OP:                        d.sel = IMM_NONE;
         default:                       d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/immgen.sv
// Immediate generator: sign-extends the selected RISC-V immediate format to XLEN.
module immgen
   import immtypes_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr_i,
   input  logic [2:0]      sel_i,
   output logic [XLEN-1:0] imm_o
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (sel_i)
         IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   imm32 = {instr_i[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller and ID/EX pipeline register with load-use stall,
// flush and EX backpressure handling plus a saturating stall-cycle counter.
module id_stage_ctrl
   import immtypes_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int REG_AW         = 5,
   parameter int LOAD_USE_STALL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [31:0]       if_instr_i,
   input  logic [XLEN-1:0]   if_pc_i,
   input  logic              flush_i,
   input  logic              hz_ld_valid_i,
   input  logic [REG_AW-1:0] hz_ld_rd_i,
   output logic              ex_valid_o,
   input  logic              ex_ready_i,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [XLEN-1:0]   ex_imm_o,
   output logic [2:0]        ex_imm_sel_o,
   output logic [6:0]        ex_opcode_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [REG_AW-1:0] ex_rs1_o,
   output logic [REG_AW-1:0] ex_rs2_o,
   output logic              ex_is_load_o,
   output logic              ex_illegal_o,
   output logic [31:0]       stall_cnt_o
);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [2:0]        sel;
      logic [6:0]        opcode;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              is_load;
      logic              illegal;
   } ex_t;

   id_state_e         state_q, state_d;
   ex_t               ex_q, ex_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   dec_t              dec;
   logic [XLEN-1:0]   imm_w;
   logic [REG_AW-1:0] rd_w, rs1_w, rs2_w;
   logic              hazard, accept;

   assign dec   = decode_opcode(if_instr_i[6:0]);
   assign rd_w  = REG_AW'(if_instr_i[11:7]);
   assign rs1_w = REG_AW'(if_instr_i[19:15]);
   assign rs2_w = REG_AW'(if_instr_i[24:20]);

   immgen #(.XLEN(XLEN)) u_immgen (
      .instr_i (if_instr_i[31:7]),
      .sel_i   (dec.sel),
      .imm_o   (imm_w)
   );

   assign hazard = (LOAD_USE_STALL != 0) && if_valid_i && hz_ld_valid_i &&
                   (hz_ld_rd_i != '0) &&
                   ((dec.uses_rs1 && (rs1_w == hz_ld_rd_i)) ||
                    (dec.uses_rs2 && (rs2_w == hz_ld_rd_i)));

   assign ex_valid_o = (state_q == VALID);
   assign if_ready_o = (!ex_valid_o || ex_ready_i) && !hazard && !flush_i;
   assign accept     = if_valid_i && if_ready_o;

   // Flush dominates; a hazard only opens a bubble once any held instruction has left.
   always_comb begin
      state_d     = state_q;
      ex_d        = ex_q;
      stall_cnt_d = stall_cnt_q;
      if (flush_i)
         state_d = EMPTY;
      else if (accept)
         state_d = VALID;
      else if (hazard && ((state_q != VALID) || ex_ready_i))
         state_d = BUBBLE;
      else if ((state_q == VALID) && !ex_ready_i)
         state_d = VALID;
      else
         state_d = EMPTY;

      if (accept) begin
         ex_d.pc      = if_pc_i;
         ex_d.imm     = imm_w;
         ex_d.sel     = dec.sel;
         ex_d.opcode  = if_instr_i[6:0];
         ex_d.rd      = rd_w;
         ex_d.rs1     = rs1_w;
         ex_d.rs2     = rs2_w;
         ex_d.is_load = dec.is_load;
         ex_d.illegal = dec.illegal;
      end

      if (hazard && !flush_i && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         ex_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ex_q        <= ex_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_pc_o      = ex_q.pc;
   assign ex_imm_o     = ex_q.imm;
   assign ex_imm_sel_o = ex_q.sel;
   assign ex_opcode_o  = ex_q.opcode;
   assign ex_rd_o      = ex_q.rd;
   assign ex_rs1_o     = ex_q.rs1;
   assign ex_rs2_o     = ex_q.rs2;
   assign ex_is_load_o = ex_q.is_load;
   assign ex_illegal_o = ex_q.illegal;
   assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: expected ID/EX contents are queued
// when an instruction is offered and compared one cycle later.
module tb_id_stage_ctrl;
   import immtypes_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid_i, if_ready_o, flush_i, hz_ld_valid_i, ex_valid_o, ex_ready_i;
   logic [31:0] if_instr_i, if_pc_i, ex_pc_o, ex_imm_o, stall_cnt_o;
   logic [4:0]  hz_ld_rd_i, ex_rd_o, ex_rs1_o, ex_rs2_o;
   logic [2:0]  ex_imm_sel_o;
   logic [6:0]  ex_opcode_o;
   logic        ex_is_load_o, ex_illegal_o;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  sel;
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        ld;
      logic        ill;
   } obs_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  sel;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        ld;
      logic        ill;
   } vec_t;

   obs_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_stall;

   id_stage_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_USE_STALL(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
      .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
      .flush_i(flush_i), .hz_ld_valid_i(hz_ld_valid_i), .hz_ld_rd_i(hz_ld_rd_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o), .ex_imm_sel_o(ex_imm_sel_o),
      .ex_opcode_o(ex_opcode_o), .ex_rd_o(ex_rd_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
      .ex_is_load_o(ex_is_load_o), .ex_illegal_o(ex_illegal_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic obs_t observe();
      return {ex_valid_o, ex_pc_o, ex_imm_o, ex_imm_sel_o, ex_opcode_o,
              ex_rd_o, ex_rs1_o, ex_rs2_o, ex_is_load_o, ex_illegal_o};
   endfunction

   function automatic obs_t expect_of(input vec_t v);
      return {1'b1, v.pc, v.imm, v.sel, v.instr[6:0], v.rd, v.rs1, v.rs2, v.ld, v.ill};
   endfunction

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic fl, input logic hv, input logic [4:0] hrd, input logic er);
      if_valid_i    = v;
      if_instr_i    = instr;
      if_pc_i       = pc;
      flush_i       = fl;
      hz_ld_valid_i = hv;
      hz_ld_rd_i    = hrd;
      ex_ready_i    = er;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t o;
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
      #12;
      o = observe();
      n_cmp++;
      if (o !== '0) begin
         n_bad++;
         $display("[TB] FAIL reset_outputs: got %h want 0", o);
      end
      n_cmp++;
      if (stall_cnt_o !== 32'd0) begin
         n_bad++;
         $display("[TB] FAIL reset_stall: got %0d want 0", stall_cnt_o);
      end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (if_ready_o !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL reset_ready: got %b want 1", if_ready_o);
      end
      exp_stall = 32'd0;
   endtask

   task automatic test_immediates();
      vec_t tbl[7];
      obs_t o, e;
      logic [11:0] i12;
      logic [4:0]  r1, rdr;
      vec_t v;
      tbl[0] = '{32'hFFF10093, 32'h100, 32'hFFFFFFFF, IMM_I,    5'd1,  5'd2,  5'd31, 1'b0, 1'b0};
      tbl[1] = '{32'hFFDFF06F, 32'h104, 32'hFFFFFFFC, IMM_J,    5'd0,  5'd31, 5'd29, 1'b0, 1'b0};
      tbl[2] = '{32'h123451B7, 32'h108, 32'h12345000, IMM_U,    5'd3,  5'd8,  5'd3,  1'b0, 1'b0};
      tbl[3] = '{32'h0000007F, 32'h10C, 32'h00000000, IMM_NONE, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1};
      tbl[4] = '{32'h00512423, 32'h110, 32'h00000008, IMM_S,    5'd8,  5'd2,  5'd5,  1'b0, 1'b0};
      tbl[5] = '{32'hFE208CE3, 32'h114, 32'hFFFFFFF8, IMM_B,    5'd25, 5'd1,  5'd2,  1'b0, 1'b0};
      tbl[6] = '{32'h0000A283, 32'h118, 32'h00000000, IMM_I,    5'd5,  5'd1,  5'd0,  1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, tbl[i].instr, tbl[i].pc, 1'b0, 1'b0, 5'd0, 1'b1);
         #1;
         n_cmp++;
         if (if_ready_o !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL imm_ready[%0d]: got %b want 1", i, if_ready_o);
         end
         sb.push_back(expect_of(tbl[i]));
         tick();
         o = observe();
         e = sb.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("[TB] FAIL imm_vec[%0d]: got %h want %h", i, o, e);
         end
      end
      for (int i = 0; i < 6; i++) begin
         i12 = 12'($urandom);
         r1  = 5'($urandom);
         rdr = 5'($urandom);
         v = '{{i12, r1, 3'b000, rdr, 7'b0010011}, 32'h1000 + 32'(i * 4),
               {{20{i12[11]}}, i12}, IMM_I, rdr, r1, i12[4:0], 1'b0, 1'b0};
         drive(1'b1, v.instr, v.pc, 1'b0, 1'b0, 5'd0, 1'b1);
         sb.push_back(expect_of(v));
         tick();
         o = observe();
         e = sb.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("[TB] FAIL addi_rand[%0d]: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_backpressure();
      obs_t held, o, e;
      vec_t v;
      held = observe();
      v = '{32'h00512423, 32'h200, 32'h00000008, IMM_S, 5'd8, 5'd2, 5'd5, 1'b0, 1'b0};
      drive(1'b1, v.instr, v.pc, 1'b0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (if_ready_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL bp_ready[%0d]: got %b want 0", i, if_ready_o);
         end
         tick();
         o = observe();
         n_cmp++;
         if (o !== held) begin
            n_bad++;
            $display("[TB] FAIL bp_hold[%0d]: got %h want %h", i, o, held);
         end
      end
      ex_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (if_ready_o !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL bp_release_ready: got %b want 1", if_ready_o);
      end
      sb.push_back(expect_of(v));
      tick();
      o = observe();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
         n_bad++;
         $display("[TB] FAIL bp_next: got %h want %h", o, e);
      end
   endtask

   task automatic test_load_use();
      obs_t o, e;
      vec_t v;
      drive(1'b1, 32'h00728333, 32'h300, 1'b0, 1'b1, 5'd5, 1'b1);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if (if_ready_o !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL lu_ready[%0d]: got %b want 0", i, if_ready_o);
         end
         tick();
         exp_stall = exp_stall + 32'd1;
         n_cmp++;
         if ({ex_valid_o, stall_cnt_o} !== {1'b0, exp_stall}) begin
            n_bad++;
            $display("[TB] FAIL lu_bubble[%0d]: got valid=%b cnt=%0d want valid=0 cnt=%0d",
                     i, ex_valid_o, stall_cnt_o, exp_stall);
         end
      end
      hz_ld_valid_i = 1'b0;
      #1;
      n_cmp++;
      if (if_ready_o !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL lu_release_ready: got %b want 1", if_ready_o);
      end
      v = '{32'h00728333, 32'h300, 32'h0, IMM_NONE, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0};
      sb.push_back(expect_of(v));
      tick();
      o = observe();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
         n_bad++;
         $display("[TB] FAIL lu_accept: got %h want %h", o, e);
      end
      // x0 as load destination never stalls
      drive(1'b1, 32'h00728333, 32'h304, 1'b0, 1'b1, 5'd0, 1'b1);
      v.pc = 32'h304;
      sb.push_back(expect_of(v));
      tick();
      o = observe();
      e = sb.pop_front();
      n_cmp++;
      if ({o, stall_cnt_o} !== {e, exp_stall}) begin
         n_bad++;
         $display("[TB] FAIL lu_x0: got %h cnt=%0d want %h cnt=%0d", o, stall_cnt_o, e, exp_stall);
      end
      drive(1'b1, 32'h00728333, 32'h308, 1'b0, 1'b1, 5'd7, 1'b1);
      tick();
      exp_stall = exp_stall + 32'd1;
      n_cmp++;
      if ({ex_valid_o, stall_cnt_o} !== {1'b0, exp_stall}) begin
         n_bad++;
         $display("[TB] FAIL lu_rs2: got valid=%b cnt=%0d want valid=0 cnt=%0d",
                  ex_valid_o, stall_cnt_o, exp_stall);
      end
      // LUI ignores its rs1 field, so a matching load must not stall it
      drive(1'b1, 32'h123451B7, 32'h30C, 1'b0, 1'b1, 5'd8, 1'b1);
      v = '{32'h123451B7, 32'h30C, 32'h12345000, IMM_U, 5'd3, 5'd8, 5'd3, 1'b0, 1'b0};
      sb.push_back(expect_of(v));
      tick();
      o = observe();
      e = sb.pop_front();
      n_cmp++;
      if ({o, stall_cnt_o} !== {e, exp_stall}) begin
         n_bad++;
         $display("[TB] FAIL lu_lui: got %h cnt=%0d want %h cnt=%0d", o, stall_cnt_o, e, exp_stall);
      end
   endtask

   task automatic test_flush();
      obs_t o, e;
      vec_t v;
      drive(1'b1, 32'h00728333, 32'h400, 1'b1, 1'b1, 5'd5, 1'b0);
      #1;
      n_cmp++;
      if (if_ready_o !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL flush_ready: got %b want 0", if_ready_o);
      end
      tick();
      n_cmp++;
      if ({ex_valid_o, stall_cnt_o} !== {1'b0, exp_stall}) begin
         n_bad++;
         $display("[TB] FAIL flush_clear: got valid=%b cnt=%0d want valid=0 cnt=%0d",
                  ex_valid_o, stall_cnt_o, exp_stall);
      end
      drive(1'b1, 32'h00728333, 32'h404, 1'b0, 1'b0, 5'd0, 1'b1);
      v = '{32'h00728333, 32'h404, 32'h0, IMM_NONE, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0};
      sb.push_back(expect_of(v));
      tick();
      o = observe();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
         n_bad++;
         $display("[TB] FAIL flush_resume: got %h want %h", o, e);
      end
   endtask

   task automatic test_async_reset();
      obs_t o, e;
      vec_t v;
      drive(1'b1, 32'hFFF10093, 32'h500, 1'b0, 1'b0, 5'd0, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ex_valid_o, stall_cnt_o} !== 33'd0) begin
         n_bad++;
         $display("[TB] FAIL async_reset: got valid=%b cnt=%0d want valid=0 cnt=0",
                  ex_valid_o, stall_cnt_o);
      end
      #2;
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (if_ready_o !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL async_release_ready: got %b want 1", if_ready_o);
      end
      v = '{32'hFFF10093, 32'h500, 32'hFFFFFFFF, IMM_I, 5'd1, 5'd2, 5'd31, 1'b0, 1'b0};
      sb.push_back(expect_of(v));
      tick();
      o = observe();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
         n_bad++;
         $display("[TB] FAIL async_resume: got %h want %h", o, e);
      end
   endtask

   initial begin
      test_reset();
      test_immediates();
      test_backpressure();
      test_load_use();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
Decode-stage controller and ID/EX pipeline register for the RISC pipeline. It accepts fetched instructions over a valid/ready handshake and decodes the opcode into an imm_sel_e value. It drives the immgen unit and registers the decoded fields toward EX. It also sequences load-use stalls, flushes and EX backpressure, and keeps a stall-cycle counter.

Parameters:
XLEN, 32, datapath and PC width
REG_AW, 5, register-index width
LOAD_USE_STALL, 1, 1 enables load-use hazard stalling; 0 disables the hazard term entirely

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
if_valid_i  in  1  fetch holds an instruction
if_ready_o  out  1  stage accepts this cycle (combinational)
if_instr_i  in  32  instruction word
if_pc_i  in  XLEN  instruction PC
flush_i  in  1  kill stage contents (branch/jump redirect)
hz_ld_valid_i  in  1  load currently in EX
hz_ld_rd_i  in  REG_AW  destination register of that load
ex_valid_o  out  1  ID/EX register valid
ex_ready_i  in  1  EX consumes this cycle
ex_pc_o  out  XLEN  registered PC
ex_imm_o  out  XLEN  registered immgen result
ex_imm_sel_o  out  3  registered imm_sel_e
ex_opcode_o  out  7  instr[6:0]
ex_rd_o / ex_rs1_o / ex_rs2_o  out  REG_AW each  instr[11:7] / [19:15] / [24:20]
ex_is_load_o  out  1  opcode is LOAD
ex_illegal_o  out  1  unrecognised opcode
stall_cnt_o  out  32  saturating load-use stall-cycle count

Behaviour:
- Reset: all outputs and registers are 0, and the state is EMPTY.
- Opcode to imm_sel:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111 → IMM_I
  - STORE 0100011 → IMM_S
  - BRANCH 1100011 → IMM_B
  - LUI 0110111, AUIPC 0010111 → IMM_U
  - JAL 1101111 → IMM_J
  - OP 0110011 → IMM_NONE, immediate 0
  - Any other opcode, or instr[1:0]≠11 → IMM_NONE, immediate 0, illegal=1. The instruction still flows with valid=1.
- Register usage:
  - uses_rs1 is true for every opcode except LUI, AUIPC and JAL.
  - uses_rs2 is true for BRANCH, STORE and OP.
- hazard = LOAD_USE_STALL & if_valid_i & hz_ld_valid_i & (hz_ld_rd_i≠0) & ((uses_rs1 & rs1==hz_ld_rd_i) | (uses_rs2 & rs2==hz_ld_rd_i)).
- if_ready_o = (~ex_valid_o | ex_ready_i) & ~hazard & ~flush_i.
- accept = if_valid_i & if_ready_o. On accept, all ex_* fields load at the next edge, so latency is 1 cycle.
- State machine:
  - EMPTY (ex_valid_o=0): accept → VALID; hazard → BUBBLE; otherwise stay.
  - VALID (ex_valid_o=1): flush → EMPTY; accept → VALID with new data; ex_ready_i & ~accept → EMPTY; ~ex_ready_i → hold all fields.
  - BUBBLE (ex_valid_o=0, a stall in progress): hazard persists → BUBBLE; flush → EMPTY; accept → VALID; otherwise → EMPTY.
- Flush has highest priority. In the flush cycle nothing is accepted and valid clears at the next edge. Data fields are not cleared; consumers qualify data with ex_valid_o.
- Hazard in VALID with ex_ready_i=1: the held instruction retires, ex_valid_o→0, and the next state is BUBBLE.
- stall_cnt_o increments by 1 on every cycle with hazard & ~flush_i. It saturates at 32'hFFFFFFFF.
- Asynchronous reset mid-transfer clears valid and the counter immediately, without waiting for a clock edge.

Decomposition:
- immtypes_pkg gains IMM_NONE and fixes imm_sel_e at 3 bits. It also gains opcode localparams (OPC_LOAD … OPC_JAL) and the state enum id_state_e {EMPTY, VALID, BUBBLE}.
- The existing immgen unit is instantiated combinationally on if_instr_i; its output is registered here.
- No other sub-module.

Test Plan:
- Reset: stream instructions, pull rst_n low mid-cycle → ex_valid_o=0 and stall_cnt_o=0 before the next edge; if_ready_o=1 after release.
- Immediates: accept pc=0x100 with 0xFFF10093 (addi x1,x2,-1) → next cycle ex_valid_o=1, ex_pc_o=0x100, ex_imm_o=0xFFFFFFFF, sel IMM_I, rd=1, rs1=2.
  - 0xFFDFF06F (jal x0,-4) → ex_imm_o=0xFFFFFFFC, sel IMM_J.
  - 0x123451B7 (lui x3) → ex_imm_o=0x12345000, sel IMM_U.
  - 0x0000007F → ex_illegal_o=1, ex_imm_o=0, sel IMM_NONE.
- Backpressure: ex_valid_o=1 with ex_ready_i=0 for 3 cycles → outputs stable and if_ready_o=0; ex_ready_i=1 → next instruction accepted the same cycle.
- Load-use: hz_ld_valid_i=1, hz_ld_rd_i=5, instruction 0x00728333 (add x6,x5,x7) → if_ready_o=0, state BUBBLE, ex_valid_o=0, stall_cnt_o=1. Drop hz_ld_valid_i → accepted, ex_rs1_o=5.
  - Same setup with hz_ld_rd_i=0 → no stall.
- Flush: state VALID, if_valid_i=1, ex_ready_i=0, flush_i=1 → if_ready_o=0 that cycle, ex_valid_o=0 next cycle; a simultaneous hazard does not increment stall_cnt_o.
